mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 5, ALU operation code width (ctrl_encode_def ALUOp_* values).
REQ-002 SHALL have parameter WAIT_MAX, default 15, memory-wait timeout limit in cycles (1..255).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports opcode, funct  input  6 each  fields of the latched instruction register.
REQ-006 SHALL have ports nop / zero / mem_rdy  input  1 each  all-zero instruction / ALU zero flag / memory handshake ready.
REQ-007 SHALL have ports ir_wr, pc_wr, rf_wr, dm_wr, mem_req  output  1 each  IR load, PC load, register write, data-memory write, memory request.
REQ-008 SHALL have ports alu_op (ALUOP_W), npc_op (3), ext_op (2), gpr_sel (2), wd_sel (3), a_sel (1), b_sel (1)  output  datapath selects, using the existing NPC_/EXT_/GPRSel_/WDSel_ encodings.
REQ-009 SHALL have ports state  output  3  current state; trap  output  1  trap status.

Function
REQ-010 SHALL implement a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to TRAP.
REQ-011 FETCH: mem_req=1; on mem_rdy=1 assert ir_wr=1, pc_wr=1, npc_op=NPC_PLUS4 for that cycle, next DECODE; otherwise remain.
REQ-012 DECODE: one cycle, no writes; nop=1 -> FETCH, else EXEC.
REQ-013 EXEC R-type/I-type ALU ops: alu_op, a_sel (1 for sll/srl/sra), b_sel, ext_op (signed for addi/addiu/lw/sw) driven per opcode/funct; next WB.
REQ-014 EXEC lw/sw: alu_op=ALUOp_ADD, b_sel=1, ext_op signed; next MEM.
REQ-015 EXEC beq/bne: alu_op=ALUOp_BEQ/BNE; pc_wr=zero with npc_op=NPC_BRANCH; next FETCH.
REQ-016 EXEC j/jal/jr: pc_wr=1, npc_op=NPC_JUMP (NPC_JR for jr); jal also rf_wr=1, gpr_sel=GPRSel_31, wd_sel=WDSel_FromPC; next FETCH.
REQ-017 MEM: mem_req=1; sw asserts dm_wr=1 while waiting; on mem_rdy: sw -> FETCH, lw -> WB.
REQ-018 WB: rf_wr=1 one cycle; gpr_sel=GPRSel_RD (R-type) or GPRSel_RT (I-type); wd_sel=WDSel_FromMem for lw else WDSel_FromALU; next FETCH.
REQ-019 8-bit wait counter SHALL increment each FETCH/MEM cycle with mem_rdy=0, clear on mem_rdy=1 or state exit; when it reaches WAIT_MAX with mem_rdy still 0 -> TRAP.
REQ-020 mem_rdy=1 in the same cycle the counter reaches WAIT_MAX SHALL complete the access (ready wins).
REQ-021 TRAP: trap=1, all write enables 0, mem_req=0; state held until reset.
REQ-022 Outputs not listed for a state SHALL be 0; ALU ops without a defined funct SHALL drive ALUOp_ERROR.

Reset
REQ-023 rst_n=0 SHALL immediately force state=FETCH, wait counter=0, trap=0, all write enables and mem_req 0, all selects 0, regardless of state.
REQ-024 First FETCH SHALL begin on the first rising clk after rst_n deasserts; an access interrupted by reset is abandoned.

Configuration
REQ-025 Macro MC_CTRL_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP, npc_op=NPC_EXCEPT while trap=1.
REQ-026 Macro undefined: unknown opcode treated as nop (DECODE -> FETCH, no writes); trap only from timeout.

Verification
REQ-027 addu, mem_rdy tied 1 -> FETCH,DECODE,EXEC,WB (4 cycles), rf_wr=1 only in WB, gpr_sel=GPRSel_RD.
REQ-028 lw, mem_rdy low 3 cycles in MEM -> 8 cycles total, mem_req high 4 MEM cycles, WB wd_sel=WDSel_FromMem.
REQ-029 beq with zero=1 then zero=0 -> 3 cycles each; pc_wr in EXEC only for zero=1.
REQ-030 mem_rdy held 0 in FETCH, WAIT_MAX=15 -> state=TRAP after 16 cycles; mem_rdy=1 on cycle 16 instead -> DECODE.
REQ-031 opcode 6'h3F with macro -> trap=1 after DECODE; without macro -> back to FETCH, no writes.
REQ-032 rst_n pulsed low mid-MEM sw -> dm_wr drops asynchronously, state=FETCH, trap=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM with a memory-wait timeout trap.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of skipping them.
`timescale 1ns/1ps
module mc_ctrl #(
    parameter int ALUOP_W  = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               nop,
    input  logic               zero,
    input  logic               mem_rdy,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic               rf_wr,
    output logic               dm_wr,
    output logic               mem_req,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         npc_op,
    output logic [1:0]         ext_op,
    output logic [1:0]         gpr_sel,
    output logic [2:0]         wd_sel,
    output logic               a_sel,
    output logic               b_sel,
    output logic [2:0]         state,
    output logic               trap
);
    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam logic [2:0] NPC_EXCEPT = 3'd4;
`endif
    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;
    localparam logic [1:0] GPRSel_RD = 2'd0;
    localparam logic [1:0] GPRSel_RT = 2'd1;
    localparam logic [1:0] GPRSel_31 = 2'd2;
    localparam logic [2:0] WDSel_FromALU = 3'd0;
    localparam logic [2:0] WDSel_FromMem = 3'd1;
    localparam logic [2:0] WDSel_FromPC  = 3'd2;

    localparam logic [ALUOP_W-1:0] ALUOp_ADDU  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOp_ADD   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOp_SUBU  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOp_SUB   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALUOp_AND   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALUOp_OR    = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALUOp_NOR   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALUOp_XOR   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALUOp_SLT   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALUOp_SLTU  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALUOp_SLL   = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALUOp_SRL   = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALUOp_SRA   = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALUOp_LUI   = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALUOp_BEQ   = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALUOp_BNE   = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALUOp_ERROR = ALUOP_W'(31);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
    localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALUR, C_ALUI, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_BAD
    } cls_t;

    state_t st;
    cls_t   cls;
    logic [7:0] cnt;
    logic       run;
    logic [ALUOP_W-1:0] r_alu, i_alu;
    logic [1:0] i_ext;
    logic       shift;

    always_comb begin
        cls = C_BAD;
        case (opcode)
            OP_RTYPE: cls = (funct == F_JR) ? C_JR : C_ALUR;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: cls = C_ALUI;
            OP_LW:  cls = C_LW;
            OP_SW:  cls = C_SW;
            OP_BEQ, OP_BNE: cls = C_BR;
            OP_J:   cls = C_J;
            OP_JAL: cls = C_JAL;
            default: cls = C_BAD;
        endcase
    end

    always_comb begin
        r_alu = ALUOp_ERROR;
        case (funct)
            F_SLL:  r_alu = ALUOp_SLL;
            F_SRL:  r_alu = ALUOp_SRL;
            F_SRA:  r_alu = ALUOp_SRA;
            F_ADD:  r_alu = ALUOp_ADD;
            F_ADDU: r_alu = ALUOp_ADDU;
            F_SUB:  r_alu = ALUOp_SUB;
            F_SUBU: r_alu = ALUOp_SUBU;
            F_AND:  r_alu = ALUOp_AND;
            F_OR:   r_alu = ALUOp_OR;
            F_XOR:  r_alu = ALUOp_XOR;
            F_NOR:  r_alu = ALUOp_NOR;
            F_SLT:  r_alu = ALUOp_SLT;
            F_SLTU: r_alu = ALUOp_SLTU;
            default: r_alu = ALUOp_ERROR;
        endcase
        shift = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
    end

    always_comb begin
        i_alu = ALUOp_ERROR;
        i_ext = EXT_ZERO;
        case (opcode)
            OP_ADDI:  begin i_alu = ALUOp_ADD;  i_ext = EXT_SIGNED;  end
            OP_ADDIU: begin i_alu = ALUOp_ADDU; i_ext = EXT_SIGNED;  end
            OP_ANDI:  i_alu = ALUOp_AND;
            OP_ORI:   i_alu = ALUOp_OR;
            OP_LUI:   begin i_alu = ALUOp_LUI;  i_ext = EXT_HIGHPOS; end
            default:  i_alu = ALUOp_ERROR;
        endcase
    end

    // run holds the FSM idle until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_FETCH;
            cnt <= 8'd0;
            run <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (st)
                S_FETCH, S_MEM: begin
                    if (mem_rdy) begin
                        cnt <= 8'd0;
                        if (st == S_FETCH) st <= S_DECODE;
                        else st <= (cls == C_SW) ? S_FETCH : S_WB;
                    end else if (cnt == WAIT_LIM) begin
                        cnt <= 8'd0;
                        st  <= S_TRAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (nop) st <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    else if (cls == C_BAD) st <= S_TRAP;
`else
                    else if (cls == C_BAD) st <= S_FETCH;
`endif
                    else st <= S_EXEC;
                end
                S_EXEC: begin
                    case (cls)
                        C_ALUR, C_ALUI: st <= S_WB;
                        C_LW, C_SW:     st <= S_MEM;
                        default:        st <= S_FETCH;
                    endcase
                end
                S_WB:    st <= S_FETCH;
                S_TRAP:  st <= S_TRAP;
                default: st <= S_TRAP;
            endcase
        end
    end

    assign state = st;

    always_comb begin
        ir_wr = 1'b0; pc_wr = 1'b0; rf_wr = 1'b0; dm_wr = 1'b0;
        mem_req = 1'b0; alu_op = '0; npc_op = NPC_PLUS4;
        ext_op = EXT_ZERO; gpr_sel = GPRSel_RD; wd_sel = WDSel_FromALU;
        a_sel = 1'b0; b_sel = 1'b0; trap = 1'b0;
        if (run) begin
            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_wr   = mem_rdy;
                    pc_wr   = mem_rdy;
                    npc_op  = NPC_PLUS4;
                end
                S_DECODE: ;
                S_EXEC: begin
                    case (cls)
                        C_ALUR: begin alu_op = r_alu; a_sel = shift; end
                        C_ALUI: begin alu_op = i_alu; b_sel = 1'b1; ext_op = i_ext; end
                        C_LW, C_SW: begin
                            alu_op = ALUOp_ADD; b_sel = 1'b1; ext_op = EXT_SIGNED;
                        end
                        C_BR: begin
                            alu_op = (opcode == OP_BEQ) ? ALUOp_BEQ : ALUOp_BNE;
                            pc_wr  = zero;
                            npc_op = NPC_BRANCH;
                        end
                        C_J:  begin pc_wr = 1'b1; npc_op = NPC_JUMP; end
                        C_JR: begin pc_wr = 1'b1; npc_op = NPC_JR; end
                        C_JAL: begin
                            pc_wr = 1'b1; npc_op = NPC_JUMP; rf_wr = 1'b1;
                            gpr_sel = GPRSel_31; wd_sel = WDSel_FromPC;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    dm_wr   = (cls == C_SW);
                end
                S_WB: begin
                    rf_wr   = 1'b1;
                    gpr_sel = (cls == C_ALUR) ? GPRSel_RD : GPRSel_RT;
                    wd_sel  = (cls == C_LW) ? WDSel_FromMem : WDSel_FromALU;
                end
                default: begin
                    trap = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    npc_op = NPC_EXCEPT;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction traces for mc_ctrl, checked every cycle.
// Traces are assembled from per-state sequencing helpers and hand-set vectors.
`timescale 1ns/1ps
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic nop = 1'b0, zero = 1'b0, mem_rdy = 1'b0;
    logic ir_wr, pc_wr, rf_wr, dm_wr, mem_req, a_sel, b_sel, trap;
    logic [4:0] alu_op;
    logic [2:0] npc_op, wd_sel, state;
    logic [1:0] ext_op, gpr_sel;
    int checks = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .nop(nop), .zero(zero), .mem_rdy(mem_rdy),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .rf_wr(rf_wr), .dm_wr(dm_wr),
        .mem_req(mem_req), .alu_op(alu_op), .npc_op(npc_op),
        .ext_op(ext_op), .gpr_sel(gpr_sel), .wd_sel(wd_sel),
        .a_sel(a_sel), .b_sel(b_sel), .state(state), .trap(trap)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
    localparam logic [2:0] N_BR = 3'd1, N_JMP = 3'd2, N_JR = 3'd3, N_EXC = 3'd4;
    localparam logic [1:0] E_SGN = 2'd1, E_HI = 2'd2;
    localparam logic [1:0] G_RD = 2'd0, G_RT = 2'd1, G_31 = 2'd2;
    localparam logic [2:0] W_ALU = 3'd0, W_MEM = 3'd1, W_PC = 3'd2;
    localparam logic [4:0] A_ADDU = 5'd1, A_ADD = 5'd2, A_SUBU = 5'd3;
    localparam logic [4:0] A_OR = 5'd6, A_SLL = 5'd11, A_SRA = 5'd13;
    localparam logic [4:0] A_LUI = 5'd14, A_BEQ = 5'd15, A_BNE = 5'd16, A_ERR = 5'd31;

    typedef struct packed {
        logic [2:0] st;
        logic       trap, ir, pc, rf, dm, mreq;
        logic [4:0] alu;
        logic [2:0] npc;
        logic [1:0] ext, gsel;
        logic [2:0] wd;
        logic       asel, bsel;
    } vec_t;

    typedef struct {
        logic [5:0] op, fn;
        logic rdy, z, n;
        vec_t e;
        string tag;
    } step_t;

    step_t q[$];
    logic [5:0] cur_op, cur_fn;
    string cur_name;
    vec_t act;

    assign act = {state, trap, ir_wr, pc_wr, rf_wr, dm_wr, mem_req, alu_op,
                  npc_op, ext_op, gpr_sel, wd_sel, a_sel, b_sel};

    task automatic chk(string tag, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", tag, a, e);
        end
    endtask

    function automatic vec_t vs(logic [2:0] s);
        vec_t v;
        v = '0;
        v.st = s;
        return v;
    endfunction

    function automatic vec_t ex(logic [4:0] a, logic as, logic bs, logic [1:0] x);
        vec_t v;
        v = vs(S_E);
        v.alu = a; v.asel = as; v.bsel = bs; v.ext = x;
        return v;
    endfunction

    task automatic instr(string name, logic [5:0] op, logic [5:0] fn);
        cur_name = name; cur_op = op; cur_fn = fn;
    endtask

    task automatic push(logic rdy, logic z, logic n, vec_t e, string tag);
        step_t s;
        s.op = cur_op; s.fn = cur_fn; s.rdy = rdy; s.z = z; s.n = n;
        s.e = e; s.tag = {cur_name, "_", tag};
        q.push_back(s);
    endtask

    task automatic p_fetch(int waits, logic done);
        vec_t e;
        e = vs(S_F); e.mreq = 1'b1;
        for (int i = 0; i < waits; i++) push(1'b0, 1'b0, 1'b0, e, "fetch_wait");
        e.ir = 1'b1; e.pc = 1'b1;
        if (done) push(1'b1, 1'b0, 1'b0, e, "fetch_rdy");
    endtask

    task automatic p_decode(logic n);
        push(1'b0, 1'b0, n, vs(S_D), "decode");
    endtask

    task automatic p_exec(vec_t e, logic z);
        e.st = S_E;
        push(1'b1, z, 1'b0, e, "exec");
    endtask

    task automatic p_mem(int waits, logic sw, logic done);
        vec_t e;
        e = vs(S_M); e.mreq = 1'b1; e.dm = sw;
        for (int i = 0; i < waits; i++) push(1'b0, 1'b0, 1'b0, e, "mem_wait");
        if (done) push(1'b1, 1'b0, 1'b0, e, "mem_rdy");
    endtask

    task automatic p_wb(logic [1:0] g, logic [2:0] w);
        vec_t e;
        e = vs(S_W); e.rf = 1'b1; e.gsel = g; e.wd = w;
        push(1'b1, 1'b0, 1'b0, e, "wb");
    endtask

    task automatic p_trap(int n);
        vec_t e;
        e = vs(S_T); e.trap = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        e.npc = N_EXC;
`endif
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, e, "trap_hold");
    endtask

    task automatic run();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            opcode = s.op; funct = s.fn; mem_rdy = s.rdy; zero = s.z; nop = s.n;
            @(negedge clk);
            chk(s.tag, 32'(act), 32'(s.e));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0; mem_rdy = 1'b1;
        #1;
        chk({tag, "_async_zero"}, 32'(act), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_idle_zero"}, 32'(act), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(string name, logic [5:0] fn, logic [4:0] a, logic sh);
        instr(name, 6'h00, fn);
        p_fetch(0, 1'b1); p_decode(1'b0);
        p_exec(ex(a, sh, 1'b0, 2'd0), 1'b0);
        p_wb(G_RD, W_ALU);
        run();
    endtask

    task automatic itype(string name, logic [5:0] op, logic [4:0] a, logic [1:0] x);
        instr(name, op, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0);
        p_exec(ex(a, 1'b0, 1'b1, x), 1'b0);
        p_wb(G_RT, W_ALU);
        run();
    endtask

    task automatic branch(string name, logic [5:0] op, logic [4:0] a, logic z);
        vec_t e;
        e = vs(S_E); e.alu = a; e.pc = z; e.npc = N_BR;
        instr(name, op, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0); p_exec(e, z);
        run();
    endtask

    initial begin
        vec_t e;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        rtype("addu", 6'h21, A_ADDU, 1'b0);
        rtype("subu", 6'h23, A_SUBU, 1'b0);
        rtype("sll", 6'h00, A_SLL, 1'b1);
        rtype("sra", 6'h03, A_SRA, 1'b1);
        rtype("badfn", 6'h3F, A_ERR, 1'b0);
        itype("addi", 6'h08, A_ADD, E_SGN);
        itype("ori", 6'h0D, A_OR, 2'd0);
        itype("lui", 6'h0F, A_LUI, E_HI);

        instr("lw", 6'h23, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADD, 1'b0, 1'b1, E_SGN), 1'b0);
        p_mem(3, 1'b0, 1'b1); p_wb(G_RT, W_MEM);
        run();

        instr("lw_waits", 6'h23, 6'h00);
        p_fetch(10, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADD, 1'b0, 1'b1, E_SGN), 1'b0);
        p_mem(14, 1'b0, 1'b1); p_wb(G_RT, W_MEM);
        run();

        instr("sw", 6'h2B, 6'h00);
        p_fetch(2, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADD, 1'b0, 1'b1, E_SGN), 1'b0);
        p_mem(1, 1'b1, 1'b1);
        run();

        branch("beq_t", 6'h04, A_BEQ, 1'b1);
        branch("beq_nt", 6'h04, A_BEQ, 1'b0);
        branch("bne_t", 6'h05, A_BNE, 1'b1);

        e = vs(S_E); e.pc = 1'b1; e.npc = N_JMP;
        instr("j", 6'h02, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0); p_exec(e, 1'b0);
        e.rf = 1'b1; e.gsel = G_31; e.wd = W_PC;
        instr("jal", 6'h03, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0); p_exec(e, 1'b0);
        e = vs(S_E); e.pc = 1'b1; e.npc = N_JR;
        instr("jr", 6'h00, 6'h08);
        p_fetch(0, 1'b1); p_decode(1'b0); p_exec(e, 1'b0);
        instr("nop", 6'h00, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b1);
        instr("rdy_wins", 6'h21, 6'h21);
        p_fetch(15, 1'b1); p_decode(1'b1);
        run();

        instr("illegal", 6'h3F, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        p_trap(2);
`else
        p_fetch(1, 1'b0);
`endif
        run();
        chk("illegal_trap_flag", 32'(trap),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            32'd1);
`else
            32'd0);
`endif
        do_reset("illegal_reset");

        instr("fetch_timeout", 6'h21, 6'h21);
        p_fetch(16, 1'b0); p_trap(3);
        run();
        chk("fetch_timeout_state", 32'(state), 32'(S_T));
        do_reset("fetch_timeout_reset");

        instr("mem_timeout", 6'h23, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADD, 1'b0, 1'b1, E_SGN), 1'b0);
        p_mem(16, 1'b0, 1'b0); p_trap(2);
        run();
        do_reset("mem_timeout_reset");

        instr("sw_reset", 6'h2B, 6'h00);
        p_fetch(0, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADD, 1'b0, 1'b1, E_SGN), 1'b0);
        p_mem(2, 1'b1, 1'b0);
        run();
        chk("sw_reset_dm_before", 32'(dm_wr), 32'd1);
        do_reset("sw_reset");
        chk("sw_reset_state", 32'(state), 32'(S_F));

        instr("post_reset_addu", 6'h00, 6'h21);
        p_fetch(1, 1'b1); p_decode(1'b0);
        p_exec(ex(A_ADDU, 1'b0, 1'b0, 2'd0), 1'b0);
        p_wb(G_RD, W_ALU);
        run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
